// File: rtl/pipe_hazard_ctl.sv
// Pipeline hazard controller: memory-wait stalls with timeout, taken-branch flush,
// load-use interlock, and a saturating count of PC-hold cycles.
module pipe_hazard_ctl #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [0:4]       id_rs1,
   input  logic [0:4]       id_rs2,
   input  logic             id_uses_rs2,
   input  logic [0:4]       ex_destReg,
   input  logic             ex_load,
   input  logic             branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_hold,
   output logic [0:1]       ifid_ctl,
   output logic [0:1]       idex_ctl,
   output logic [0:1]       exmem_ctl,
   output logic [0:1]       memwb_ctl,
   output logic             mem_error,
   output logic [0:CNT_W-1] stall_cnt,
   output logic [0:1]       state
);

   localparam int unsigned WC_W = $clog2(TIMEOUT + 1);

   localparam logic [1:0] CTL_LOAD  = 2'b00;
   localparam logic [1:0] CTL_HOLD  = 2'b01;
   localparam logic [1:0] CTL_FLUSH = 2'b10;

   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_MWAIT = 2'b01,
      ST_ERROR = 2'b10
   } state_e;

   state_e            state_q, state_d;
   logic [WC_W-1:0]   wcnt_q, wcnt_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  scnt_q, scnt_d;

   logic mem_wait;
   logic load_use;

   assign mem_wait = mem_req & ~mem_ready;

   // Register 0 is hardwired, so a load targeting it never creates a dependency.
   assign load_use = ex_load && (ex_destReg != 5'd0) &&
                     ((ex_destReg == id_rs1) || (id_uses_rs2 && (ex_destReg == id_rs2)));

   always_comb begin
      pc_hold   = 1'b0;
      ifid_ctl  = CTL_LOAD;
      idex_ctl  = CTL_LOAD;
      exmem_ctl = CTL_LOAD;
      memwb_ctl = CTL_LOAD;
      if (reset) begin
         pc_hold   = 1'b1;
         ifid_ctl  = CTL_FLUSH;
         idex_ctl  = CTL_FLUSH;
         exmem_ctl = CTL_FLUSH;
         memwb_ctl = CTL_FLUSH;
      end else if (state_q == ST_ERROR) begin
         pc_hold   = 1'b1;
         ifid_ctl  = CTL_HOLD;
         idex_ctl  = CTL_HOLD;
         exmem_ctl = CTL_HOLD;
         memwb_ctl = CTL_HOLD;
      end else if (mem_wait) begin
         // Freeze everything upstream of MEM and feed WB a bubble.
         pc_hold   = 1'b1;
         ifid_ctl  = CTL_HOLD;
         idex_ctl  = CTL_HOLD;
         exmem_ctl = CTL_HOLD;
         memwb_ctl = CTL_FLUSH;
      end else if (branch_taken) begin
         ifid_ctl  = CTL_FLUSH;
         idex_ctl  = CTL_FLUSH;
      end else if (load_use) begin
         pc_hold   = 1'b1;
         ifid_ctl  = CTL_HOLD;
         idex_ctl  = CTL_FLUSH;
      end
   end

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      err_d   = err_q;
      case (state_q)
         ST_RUN: begin
            wcnt_d = '0;
            if (mem_wait) begin
               state_d = ST_MWAIT;
            end
         end
         ST_MWAIT: begin
            if (mem_wait) begin
               wcnt_d = wcnt_q + 1'b1;
               // The edge on which the counter reaches TIMEOUT enters ERROR.
               if (wcnt_q == WC_W'(TIMEOUT - 1)) begin
                  state_d = ST_ERROR;
                  err_d   = 1'b1;
               end
            end else begin
               state_d = ST_RUN;
               wcnt_d  = '0;
            end
         end
         ST_ERROR: begin
            err_d = 1'b1;
         end
         default: begin
            state_d = ST_RUN;
            wcnt_d  = '0;
         end
      endcase
   end

   always_comb begin
      scnt_d = scnt_q;
      if (pc_hold && (scnt_q != {CNT_W{1'b1}})) begin
         scnt_d = scnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_RUN;
         wcnt_q  <= '0;
         err_q   <= 1'b0;
         scnt_q  <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         err_q   <= err_d;
         scnt_q  <= scnt_d;
      end
   end

   assign mem_error = err_q;
   assign stall_cnt = scnt_q;
   assign state     = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Bench for pipe_hazard_ctl: vector table, hand-written multi-cycle sequences,
// and randomized traffic against a rule-level reference model.
module tb_pipe_hazard_ctl;

   localparam int TO = 4;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [0:4]    id_rs1, id_rs2, ex_destReg;
   logic          id_uses_rs2, ex_load, branch_taken, mem_req, mem_ready;
   logic          pc_hold;
   logic [0:1]    ifid_ctl, idex_ctl, exmem_ctl, memwb_ctl;
   logic          mem_error;
   logic [0:CW-1] stall_cnt;
   logic [0:1]    state;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   bit m_err, m_wait;
   int m_waited, m_stalls;

   pipe_hazard_ctl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
      .ex_destReg(ex_destReg), .ex_load(ex_load), .branch_taken(branch_taken),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_hold(pc_hold), .ifid_ctl(ifid_ctl), .idex_ctl(idex_ctl),
      .exmem_ctl(exmem_ctl), .memwb_ctl(memwb_ctl),
      .mem_error(mem_error), .stall_cnt(stall_cnt), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] rs1, rs2;
      logic       uses;
      logic [4:0] exd;
      logic       ld, br, req, rdy;
      logic [8:0] ctl;
      logic [1:0] st;
      logic [3:0] cnt;
   } vec_t;

   vec_t vecs[11];

   function automatic logic [8:0] got_ctl();
      return {pc_hold, ifid_ctl, idex_ctl, exmem_ctl, memwb_ctl};
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Outputs derived directly from the hazard priority rules.
   function automatic logic [8:0] model_ctl();
      if (reset)                    return 9'b1_10_10_10_10;
      if (m_err)                    return 9'b1_01_01_01_01;
      if (mem_req && !mem_ready)    return 9'b1_01_01_01_10;
      if (branch_taken)             return 9'b0_10_10_00_00;
      if (ex_load && ex_destReg != 5'd0 &&
          (ex_destReg == id_rs1 || (id_uses_rs2 && ex_destReg == id_rs2)))
                                    return 9'b1_01_10_00_00;
      return 9'b0;
   endfunction

   function automatic logic [1:0] model_state();
      if (m_err)  return 2'b10;
      if (m_wait) return 2'b01;
      return 2'b00;
   endfunction

   task automatic model_reset();
      m_err = 0; m_wait = 0; m_waited = 0; m_stalls = 0;
   endtask

   task automatic model_edge(input logic hold);
      if (reset) begin
         model_reset();
         return;
      end
      if (hold && m_stalls < (1 << CW) - 1) m_stalls++;
      if (m_err) return;
      if (mem_req && !mem_ready) begin
         if (m_wait) begin
            m_waited++;
            if (m_waited == TO) m_err = 1;
         end else begin
            m_wait = 1;
         end
      end else begin
         m_wait = 0;
         m_waited = 0;
      end
   endtask

   task automatic clear_inputs();
      id_rs1 = '0; id_rs2 = '0; id_uses_rs2 = 0; ex_destReg = '0;
      ex_load = 0; branch_taken = 0; mem_req = 0; mem_ready = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse();
      reset = 1;
      tick();
      reset = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 9'b0_00_00_00_00, 2'd0, 4'd0};
      vecs[1]  = '{5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 9'b1_01_10_00_00, 2'd0, 4'd1};
      vecs[2]  = '{5'd1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 9'b0_00_00_00_00, 2'd0, 4'd0};
      vecs[3]  = '{5'd1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 9'b1_01_10_00_00, 2'd0, 4'd1};
      vecs[4]  = '{5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 9'b0_00_00_00_00, 2'd0, 4'd0};
      vecs[5]  = '{5'd5, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 9'b0_00_00_00_00, 2'd0, 4'd0};
      vecs[6]  = '{5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 9'b0_10_10_00_00, 2'd0, 4'd0};
      vecs[7]  = '{5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 9'b0_10_10_00_00, 2'd0, 4'd0};
      vecs[8]  = '{5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 9'b1_01_01_01_10, 2'd1, 4'd1};
      vecs[9]  = '{5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 9'b1_01_10_00_00, 2'd0, 4'd1};
      vecs[10] = '{5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 9'b1_01_10_00_00, 2'd0, 4'd1};

      clear_inputs();
      reset = 1;
      #1;
      chk("reset_ctl", got_ctl(), 9'b1_10_10_10_10);
      chk("reset_regs", {mem_error, stall_cnt, state}, 7'b0);
      tick();
      tick();
      reset = 0;

      // Single-cycle vector table, each from a fresh reset
      for (int v = 0; v < 11; v++) begin
         reset_pulse();
         id_rs1 = vecs[v].rs1; id_rs2 = vecs[v].rs2; id_uses_rs2 = vecs[v].uses;
         ex_destReg = vecs[v].exd; ex_load = vecs[v].ld; branch_taken = vecs[v].br;
         mem_req = vecs[v].req; mem_ready = vecs[v].rdy;
         #1;
         chk($sformatf("vec%0d_ctl", v), got_ctl(), vecs[v].ctl);
         tick();
         chk($sformatf("vec%0d_regs", v), {state, stall_cnt}, {vecs[v].st, vecs[v].cnt});
         $display("[TB] vec %0d ctl=%b state=%b cnt=%0d", v, got_ctl(), state, stall_cnt);
         clear_inputs();
      end

      // Load-use stall lasts one cycle
      reset_pulse();
      ex_load = 1; ex_destReg = 5'd5; id_rs1 = 5'd5;
      #1;
      chk("lu_stall", got_ctl(), 9'b1_01_10_00_00);
      tick();
      ex_load = 0;
      #1;
      chk("lu_release", got_ctl(), 9'b0);
      chk("lu_cnt", stall_cnt, 4'd1);
      tick();
      chk("lu_cnt_hold", stall_cnt, 4'd1);
      $display("[TB] load-use seq cnt=%0d", stall_cnt);
      clear_inputs();

      // Three-cycle memory wait
      reset_pulse();
      mem_req = 1; mem_ready = 0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("mw%0d_ctl", k), got_ctl(), 9'b1_01_01_01_10);
         chk($sformatf("mw%0d_state", k), state, (k == 0) ? 2'b00 : 2'b01);
         tick();
      end
      mem_ready = 1;
      #1;
      chk("mw_done_ctl", got_ctl(), 9'b0);
      chk("mw_done_state", state, 2'b01);
      chk("mw_cnt", stall_cnt, 4'd3);
      tick();
      chk("mw_back_run", {state, stall_cnt}, {2'b00, 4'd3});
      $display("[TB] mem-wait seq state=%b cnt=%0d", state, stall_cnt);
      clear_inputs();

      // Timeout into ERROR, saturation while stuck, async reset out
      reset_pulse();
      mem_req = 1; mem_ready = 0;
      repeat (4) tick();
      chk("to_pre", {mem_error, state}, {1'b0, 2'b01});
      tick();
      chk("to_err", {mem_error, state, stall_cnt}, {1'b1, 2'b10, 4'd5});
      chk("to_err_ctl", got_ctl(), 9'b1_01_01_01_01);
      mem_req = 0; branch_taken = 1;
      repeat (15) tick();
      chk("sat_cnt", {state, stall_cnt}, {2'b10, 4'd15});
      chk("err_ctl_hold", got_ctl(), 9'b1_01_01_01_01);
      repeat (3) tick();
      chk("sat_stays", stall_cnt, 4'd15);
      reset = 1;
      #1;
      chk("async_clr", {mem_error, state, stall_cnt}, 7'b0);
      chk("async_ctl", got_ctl(), 9'b1_10_10_10_10);
      tick();
      reset = 0;
      $display("[TB] timeout seq cleared state=%b", state);
      clear_inputs();

      // Reset mid-wait must discard the accumulated wait count
      reset_pulse();
      mem_req = 1; mem_ready = 0;
      repeat (2) tick();
      reset = 1;
      #1;
      chk("midwait_rst", state, 2'b00);
      tick();
      reset = 0;
      repeat (4) tick();
      chk("fresh_wait", {mem_error, state}, {1'b0, 2'b01});
      $display("[TB] reset-mid-wait seq state=%b", state);
      clear_inputs();

      // Randomized traffic against the model
      reset_pulse();
      model_reset();
      for (int i = 0; i < 300; i++) begin
         logic [8:0] e;
         int rdy_pct;
         rdy_pct = ((i / 50) % 2 == 1) ? 20 : 70;
         id_rs1       = 5'($urandom_range(0, 3));
         id_rs2       = 5'($urandom_range(0, 3));
         ex_destReg   = 5'($urandom_range(0, 3));
         id_uses_rs2  = 1'($urandom_range(0, 1));
         ex_load      = ($urandom_range(0, 99) < 50);
         branch_taken = ($urandom_range(0, 99) < 20);
         mem_req      = ($urandom_range(0, 99) < 50);
         mem_ready    = ($urandom_range(0, 99) < rdy_pct);
         reset        = ($urandom_range(0, 99) < 3);
         if (reset) model_reset();
         #1;
         e = model_ctl();
         chk($sformatf("rnd%0d_ctl", i), got_ctl(), e);
         chk($sformatf("rnd%0d_regs", i), {mem_error, stall_cnt, state},
             {m_err, 4'(m_stalls), model_state()});
         $display("[TB] rnd %0d rst=%b ctl=%b state=%b cnt=%0d", i, reset, got_ctl(), state, stall_cnt);
         tick();
         model_edge(e[8]);
      end
      reset = 0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
